// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for a LEGv8-style datapath.
// Optional performance counters (cycle_count, instr_retired) are built when PERF_CNT_EN is defined.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        Reg2Loc,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        illegal,
    output logic [3:0]  state
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_retired
`endif
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        LD_WB    = 4'd7,
        MEM_WR   = 4'd8,
        CBZ      = 4'd9,
        BR       = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_LD, C_ST, C_CBZ, C_B, C_BAD
    } cls_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    state_t cur;
    cls_t   cls;
    cls_t   dec_cls;
    logic   fin;
    state_t after_fin;

    always_comb begin
        dec_cls = C_BAD;
        if (Opcode == OP_ADD || Opcode == OP_SUB || Opcode == OP_AND || Opcode == OP_ORR)
            dec_cls = C_R;
        else if (Opcode == OP_LDUR)
            dec_cls = C_LD;
        else if (Opcode == OP_STUR)
            dec_cls = C_ST;
        else if (Opcode[10:3] == 8'b10110100)
            dec_cls = C_CBZ;
        else if (Opcode[10:5] == 6'b000101)
            dec_cls = C_B;
    end

    // Final cycle of an instruction; run is only consulted here so a drop never aborts.
    assign fin = (cur == R_WB) || (cur == LD_WB) || (cur == CBZ) || (cur == BR) ||
                 (cur == MEM_WR && mem_ready);
    assign after_fin = run ? FETCH : IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= IDLE;
            cls <= C_R;
        end else begin
            case (cur)
                IDLE:     if (run) cur <= FETCH;
                FETCH:    if (mem_ready) cur <= DECODE;
                DECODE: begin
                    cls <= dec_cls;
                    case (dec_cls)
                        C_R:         cur <= EXEC_R;
                        C_LD, C_ST:  cur <= MEM_ADDR;
                        C_CBZ:       cur <= CBZ;
                        C_B:         cur <= BR;
                        default:     cur <= TRAP;
                    endcase
                end
                EXEC_R:   cur <= R_WB;
                MEM_ADDR: cur <= (cls == C_ST) ? MEM_WR : MEM_RD;
                MEM_RD:   if (mem_ready) cur <= LD_WB;
                MEM_WR:   if (mem_ready) cur <= after_fin;
                R_WB, LD_WB, CBZ, BR: cur <= after_fin;
                TRAP:     cur <= TRAP;
                default:  cur <= IDLE;
            endcase
        end
    end

    assign state = cur;

    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        Reg2Loc  = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        illegal  = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                Reg2Loc = (Opcode == OP_STUR) || (Opcode[10:3] == 8'b10110100);
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB:     RegWrite = 1'b1;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Reg2Loc = (cls == C_ST);
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            LD_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Reg2Loc  = 1'b1;
            end
            CBZ: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                Reg2Loc = 1'b1;
                PCSrc   = 1'b1;
                PCWrite = Zero;
            end
            BR: begin
                PCWrite = 1'b1;
                PCSrc   = 1'b1;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else begin
            if (cur != IDLE && cur != TRAP)
                cycle_count <= cycle_count + 1'b1;
            if (fin)
                instr_retired <= instr_retired + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model checked every cycle,
// directed sequences pinning literal state values, then randomized traffic.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n, run, Zero, mem_ready;
    logic [10:0] Opcode;
    logic        IorD, MemRead, MemWrite, IRWrite, Reg2Loc, RegWrite, MemtoReg, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp;
    logic        PCWrite, PCSrc, illegal;
    logic [3:0]  state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_count, instr_retired;
`endif

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .run(run), .Opcode(Opcode), .Zero(Zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .illegal(illegal), .state(state)
`ifdef PERF_CNT_EN
        , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord, mrd, mwr, irw, r2l, rw, m2r, srca;
        logic [1:0] srcb, aluop;
        logic       pcw, pcs, ill;
        logic [3:0] st;
    } outs_t;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_BAD = 5;
    localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000;
    localparam logic [10:0] AND_ = 11'b10001010000, ORR = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000;

    int n_chk = 0, n_pass = 0;
    int m_pos = -1, m_cls = K_R;
    logic [31:0] m_cyc = 0, m_ret = 0;
    logic pin_en = 1'b0, pin_perf = 1'b0;
    int   pin_st = 0;

    function automatic int classify(logic [10:0] op);
        if (op == ADD || op == SUB || op == AND_ || op == ORR) return K_R;
        if (op == LDUR) return K_LD;
        if (op == STUR) return K_ST;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:5] == 6'b000101) return K_B;
        return K_BAD;
    endfunction

    // Step sequence per instruction class: FETCH, DECODE, then class-specific tail.
    function automatic int st_at(int cls, int pos);
        if (pos < 0) return 0;
        if (pos == 0) return 1;
        if (pos == 1) return 2;
        case (cls)
            K_R:   return (pos == 2) ? 3 : 4;
            K_LD:  return (pos == 2) ? 5 : (pos == 3) ? 6 : 7;
            K_ST:  return (pos == 2) ? 5 : 8;
            K_CBZ: return 9;
            K_B:   return 10;
            default: return 11;
        endcase
    endfunction

    function automatic int last_pos(int cls);
        case (cls)
            K_R, K_ST:  return 3;
            K_LD:       return 4;
            K_CBZ, K_B: return 2;
            default:    return 99;
        endcase
    endfunction

    function automatic outs_t model_outs(int st, logic [10:0] op, logic mr, logic z, int cls);
        outs_t o = '0;
        o.st = st[3:0];
        case (st)
            1:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            2:  begin o.srcb = 2'b11; o.r2l = (op == STUR) || (op[10:3] == 8'b10110100); end
            3:  begin o.srca = 1; o.aluop = 2'b10; end
            4:  o.rw = 1;
            5:  begin o.srca = 1; o.srcb = 2'b10; o.r2l = (cls == K_ST); end
            6:  begin o.mrd = 1; o.iord = 1; end
            7:  begin o.rw = 1; o.m2r = 1; end
            8:  begin o.mwr = 1; o.iord = 1; o.r2l = 1; end
            9:  begin o.srca = 1; o.aluop = 2'b01; o.r2l = 1; o.pcs = 1; o.pcw = z; end
            10: begin o.pcw = 1; o.pcs = 1; end
            11: o.ill = 1;
            default: ;
        endcase
        return o;
    endfunction

    // Sole checker: compares DUT to the model each negedge, then advances the model.
    always @(negedge clk) begin
        outs_t exp_o, act_o;
        int st;
        if (!rst_n) begin
            m_pos = -1; m_cls = K_R; m_cyc = 0; m_ret = 0;
        end
        st = st_at(m_cls, m_pos);
        exp_o = model_outs(st, Opcode, mem_ready, Zero, m_cls);
        act_o = {IorD, MemRead, MemWrite, IRWrite, Reg2Loc, RegWrite, MemtoReg, ALUSrcA,
                 ALUSrcB, ALUOp, PCWrite, PCSrc, illegal, state};
        n_chk++;
        if (act_o === exp_o) n_pass++;
        else $display("FAIL outs t=%0t got %h want %h", $time, act_o, exp_o);
        if (pin_en) begin
            n_chk++;
            if (state === pin_st[3:0]) n_pass++;
            else $display("FAIL pin_state t=%0t got %0d want %0d", $time, state, pin_st);
        end
`ifdef PERF_CNT_EN
        n_chk++;
        if (cycle_count === m_cyc && instr_retired === m_ret) n_pass++;
        else $display("FAIL perf t=%0t got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                      $time, cycle_count, instr_retired, m_cyc, m_ret);
        if (pin_perf) begin
            n_chk++;
            if (cycle_count === 32'd12 && instr_retired === 32'd3) n_pass++;
            else $display("FAIL perf_pin got cyc=%0d ret=%0d want cyc=12 ret=3",
                          cycle_count, instr_retired);
        end
`endif
        if (rst_n) begin
            if (st != 0 && st != 11) m_cyc++;
            if (st == 0) begin
                if (run) m_pos = 0;
            end else if (st == 11) begin
            end else if ((st == 1 || st == 6 || st == 8) && !mem_ready) begin
            end else if (m_pos == last_pos(m_cls)) begin
                m_ret++;
                m_pos = run ? 0 : -1;
            end else begin
                if (m_pos == 1) m_cls = classify(Opcode);
                m_pos++;
            end
        end
    end

    task automatic cyc(input int exp_st);
        pin_en = (exp_st >= 0);
        pin_st = exp_st;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc(0);
        rst_n = 1'b1; run = 1'b1; mem_ready = 1'b1; cyc(0);
    endtask

    initial begin
        logic [10:0] rops [4];
        rops[0] = ADD; rops[1] = SUB; rops[2] = AND_; rops[3] = ORR;
        rst_n = 1'b0; run = 1'b0; Zero = 1'b0; mem_ready = 1'b0; Opcode = ADD;
        cyc(0); cyc(0);
        // Release with run and mem_ready high: FETCH next
        rst_n = 1'b1; run = 1'b1; mem_ready = 1'b1; cyc(0);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            Opcode = rops[i];
            cyc(2); cyc(3); cyc(4); cyc(1);
        end
        // LDUR with three wait cycles in MEM_RD
        Opcode = LDUR; cyc(2); cyc(5);
        mem_ready = 1'b0; cyc(6); cyc(6); cyc(6);
        mem_ready = 1'b1; cyc(6); cyc(7); cyc(1);
        Opcode = 11'b10110100101; Zero = 1'b1; cyc(2); cyc(9); cyc(1);
        Zero = 1'b0; cyc(2); cyc(9); cyc(1);
        Opcode = 11'b00010110011; cyc(2); cyc(10); cyc(1);
        // STUR with run dropped mid-instruction
        Opcode = STUR; cyc(2);
        run = 1'b0; cyc(5);
        mem_ready = 1'b0; cyc(8); cyc(8);
        mem_ready = 1'b1; cyc(8); cyc(0); cyc(0);
        // Illegal opcode traps until reset
        do_reset(); cyc(1);
        Opcode = 11'b11111111111; cyc(2);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom); mem_ready = 1'($urandom); Opcode = 11'($urandom);
            cyc(11);
        end
        rst_n = 1'b0; cyc(0);
        rst_n = 1'b1; run = 1'b0; cyc(0);
        // Three ADDs from reset for the performance counters
        do_reset(); Opcode = ADD;
        for (int i = 0; i < 3; i++) begin
            cyc(1); cyc(2); cyc(3);
            if (i == 2) run = 1'b0;
            cyc(4);
        end
        pin_perf = 1'b1; cyc(0); pin_perf = 1'b0;
        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 19);
            case (r)
                0, 1, 2, 3: Opcode = rops[r];
                4, 5:       Opcode = LDUR;
                6, 7:       Opcode = STUR;
                8, 9:       Opcode = {8'b10110100, 3'($urandom)};
                10, 11:     Opcode = {6'b000101, 5'($urandom)};
                12:         Opcode = 11'($urandom);
                default:    Opcode = rops[$urandom_range(0, 3)];
            endcase
            run       = ($urandom_range(0, 9) < 8);
            mem_ready = ($urandom_range(0, 9) < 7);
            Zero      = 1'($urandom);
            rst_n     = ($urandom_range(0, 59) != 0);
            cyc(-1);
        end
        pin_en = 1'b0;
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
